// File: rtl/flop_sched.sv
// Two-port arbiter in front of a shared combinational float adder.
// A winner's operands are held on the adder for SETTLE cycles, then the sum is returned.
module flop_sched #(
  parameter int unsigned W      = 13,
  parameter int unsigned SETTLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_one,
  input  logic [W-1:0] req0_other,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_one,
  input  logic [W-1:0] req1_other,
  output logic         req1_ready,
  output logic [W-1:0] add_one,
  output logic [W-1:0] add_other,
  input  logic [W-1:0] add_result,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  input  logic         rsp_ready,
  output logic         busy,
  output logic [7:0]   done_cnt
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]       state, stateNext;
  logic             lastGrant, lastGrantNext;
  logic [CNT_W-1:0] settleCnt, settleCntNext;
  logic [W-1:0]     addOneNext, addOtherNext, rspDataNext;
  logic             rspValidNext, rspIdNext;
  logic [7:0]       doneCntNext;
  logic             grant0, grant1;

  // Round-robin tie break: on a tie the port not granted last time wins.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || lastGrant);
    grant1 = req1_valid && (!req0_valid || !lastGrant);
  end

  // Accept strobes are decoded so a requester sees ready in the grant cycle itself.
  assign req0_ready = reset_n && (state == ST_IDLE) && grant0;
  assign req1_ready = reset_n && (state == ST_IDLE) && grant1;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      lastGrant <= 1'b1;
      settleCnt <= '0;
      add_one   <= '0;
      add_other <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      done_cnt  <= '0;
    end else begin
      state     <= stateNext;
      lastGrant <= lastGrantNext;
      settleCnt <= settleCntNext;
      add_one   <= addOneNext;
      add_other <= addOtherNext;
      rsp_valid <= rspValidNext;
      rsp_id    <= rspIdNext;
      rsp_data  <= rspDataNext;
      done_cnt  <= doneCntNext;
    end
  end

  always_comb begin
    stateNext     = state;
    lastGrantNext = lastGrant;
    settleCntNext = settleCnt;
    addOneNext    = add_one;
    addOtherNext  = add_other;
    rspValidNext  = rsp_valid;
    rspIdNext     = rsp_id;
    rspDataNext   = rsp_data;
    doneCntNext   = done_cnt;
    case (state)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          stateNext     = ST_SETTLE;
          lastGrantNext = grant1;
          addOneNext    = grant1 ? req1_one : req0_one;
          addOtherNext  = grant1 ? req1_other : req0_other;
          settleCntNext = CNT_W'(SETTLE - 1);
        end
      end
      ST_SETTLE: begin
        if (settleCnt == '0) begin
          stateNext    = ST_DONE;
          rspDataNext  = add_result;
          rspIdNext    = lastGrant;
          rspValidNext = 1'b1;
        end else begin
          settleCntNext = settleCnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          stateNext    = ST_IDLE;
          rspValidNext = 1'b0;
          doneCntNext  = done_cnt + 8'd1;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_flop_sched.sv
// Directed bench for flop_sched: one SETTLE=1 instance for the main flow,
// one SETTLE=3 instance for latency and response-hold checks.
module tb_flop_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0Valid, req1Valid, req0Ready, req1Ready;
  logic [12:0] req0One, req0Other, req1One, req1Other;
  logic [12:0] addOne, addOther, addResult, rspData;
  logic        rspValid, rspId, rspReady, busy;
  logic [7:0]  doneCnt;

  logic        s3Req0Valid, s3Req1Valid, s3Req0Ready, s3Req1Ready;
  logic [12:0] s3AddOne, s3AddOther, s3AddResult, s3RspData;
  logic        s3RspValid, s3RspId, s3RspReady, s3Busy;
  logic [7:0]  s3DoneCnt;

  int          nCmp = 0;
  int          nErr = 0;
  int          expDone = 0;
  logic [13:0] q[$];
  logic [13:0] ent;
  logic [12:0] prevOne, prevOther;
  logic        prevGrant = 1'b0;
  logic        prevRstN = 1'b0;

  always #5 clk = ~clk;

  // Adder stub: chosen so 0x0123 + 0x0045 lands on 0x1ABC.
  assign addResult   = addOne + addOther + 13'h1954;
  assign s3AddResult = s3AddOne + s3AddOther + 13'h1954;

  flop_sched #(.W(13), .SETTLE(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0Valid), .req0_one(req0One), .req0_other(req0Other), .req0_ready(req0Ready),
    .req1_valid(req1Valid), .req1_one(req1One), .req1_other(req1Other), .req1_ready(req1Ready),
    .add_one(addOne), .add_other(addOther), .add_result(addResult),
    .rsp_valid(rspValid), .rsp_id(rspId), .rsp_data(rspData), .rsp_ready(rspReady),
    .busy(busy), .done_cnt(doneCnt)
  );

  flop_sched #(.W(13), .SETTLE(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(s3Req0Valid), .req0_one(req0One), .req0_other(req0Other), .req0_ready(s3Req0Ready),
    .req1_valid(s3Req1Valid), .req1_one(req1One), .req1_other(req1Other), .req1_ready(s3Req1Ready),
    .add_one(s3AddOne), .add_other(s3AddOther), .add_result(s3AddResult),
    .rsp_valid(s3RspValid), .rsp_id(s3RspId), .rsp_data(s3RspData), .rsp_ready(s3RspReady),
    .busy(s3Busy), .done_cnt(s3DoneCnt)
  );

  function automatic logic [12:0] addModel(input logic [12:0] a, input logic [12:0] b);
    logic [12:0] s;
    s = a + b + 13'h1954;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop, strobe exclusivity and operand-hold monitor for the SETTLE=1 instance.
  always @(negedge clk) begin
    if (reset_n) begin
      if (req0Ready || req1Ready) begin
        chk("dualReady", 32'(req0Ready & req1Ready), 32'd0);
        chk("readyWhileBusy", 32'(busy), 32'd0);
      end
      if (rspValid && rspReady) begin
        if (q.size() == 0) chk("unexpectedRsp", 32'(rspValid), 32'd0);
        else begin
          ent = q.pop_front();
          chk("rspId", 32'(rspId), 32'(ent[13]));
          chk("rspData", 32'(rspData), 32'(ent[12:0]));
          expDone++;
        end
      end
      if (prevRstN && ((addOne !== prevOne) || (addOther !== prevOther)))
        chk("addHoldOutsideGrant", 32'(prevGrant), 32'd1);
    end
    prevOne   = addOne;
    prevOther = addOther;
    prevGrant = req0Ready | req1Ready;
    prevRstN  = reset_n;
  end

  task automatic doOp(input logic p, input logic [12:0] a, input logic [12:0] b);
    int n;
    if (p) begin req1One = a; req1Other = b; req1Valid = 1'b1; end
    else   begin req0One = a; req0Other = b; req0Valid = 1'b1; end
    n = 0;
    @(negedge clk);
    while (!(p ? req1Ready : req0Ready) && n < 20) begin @(negedge clk); n++; end
    chk("grantPort", 32'(p ? req1Ready : req0Ready), 32'd1);
    q.push_back({p, addModel(a, b)});
    @(posedge clk); #1;
    req0Valid = 1'b0;
    req1Valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin @(negedge clk); n++; end
    chk("drain", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    #1;
    q.delete();
    expDone = 0;
    @(negedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int n, cnt, saw;
    logic [12:0] holdData;
    logic        holdId;
    reset_n = 1'b0;
    req0Valid = 1'b0; req1Valid = 1'b0; rspReady = 1'b1;
    req0One = '0; req0Other = '0; req1One = '0; req1Other = '0;
    s3Req0Valid = 1'b0; s3Req1Valid = 1'b0; s3RspReady = 1'b0;
    #2;
    req0Valid = 1'b1;
    #1;
    chk("rstReady0", 32'(req0Ready), 32'd0);
    chk("rstBusy", 32'(busy), 32'd0);
    chk("rstRspValid", 32'(rspValid), 32'd0);
    chk("rstAddOne", 32'(addOne), 32'd0);
    chk("rstRspData", 32'(rspData), 32'd0);
    chk("rstDoneCnt", 32'(doneCnt), 32'd0);
    req0Valid = 1'b0;
    @(negedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single op on port 0: ready for one cycle, rsp two cycles later.
    req0One = 13'h0123; req0Other = 13'h0045; req0Valid = 1'b1;
    @(negedge clk);
    chk("basicReady0", 32'(req0Ready), 32'd1);
    chk("basicReady1", 32'(req1Ready), 32'd0);
    q.push_back({1'b0, 13'h1ABC});
    @(posedge clk); #1;
    req0Valid = 1'b0;
    @(negedge clk);
    chk("basicReadyGone", 32'(req0Ready), 32'd0);
    chk("basicBusy", 32'(busy), 32'd1);
    chk("basicRspEarly", 32'(rspValid), 32'd0);
    chk("basicAddOne", 32'(addOne), 32'h0123);
    chk("basicAddOther", 32'(addOther), 32'h0045);
    @(negedge clk);
    chk("basicRspValid", 32'(rspValid), 32'd1);
    chk("basicRspData", 32'(rspData), 32'h1ABC);
    @(negedge clk);
    chk("basicRspCleared", 32'(rspValid), 32'd0);
    chk("basicDoneCnt", 32'(doneCnt), 32'd1);
    @(posedge clk); #1;

    // Both ports held valid from reset: alternate 0,1,0,1.
    doReset();
    req0One = 13'h0111; req0Other = 13'h0222; req1One = 13'h1333; req1Other = 13'h0044;
    req0Valid = 1'b1; req1Valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clk);
      while (!(req0Ready || req1Ready) && n < 20) begin @(negedge clk); n++; end
      chk($sformatf("tieReady0_%0d", k), 32'(req0Ready), 32'(k % 2 == 0));
      chk($sformatf("tieReady1_%0d", k), 32'(req1Ready), 32'(k % 2 == 1));
      if (k % 2 == 0) q.push_back({1'b0, addModel(13'h0111, 13'h0222)});
      else            q.push_back({1'b1, addModel(13'h1333, 13'h0044)});
      @(posedge clk); #1;
      if (k == 3) begin req0Valid = 1'b0; req1Valid = 1'b0; end
    end
    drain();
    chk("tieDoneCnt", 32'(doneCnt), 32'd4);

    // Port 1 raises valid while port 0 is in flight, then withdraws.
    rspReady = 1'b0;
    doOp(1'b0, 13'h0A0A, 13'h0505);
    req1One = 13'h1FFF; req1Other = 13'h1FFF; req1Valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (req1Ready) cnt++; end
    @(posedge clk); #1;
    req1Valid = 1'b0;
    rspReady = 1'b1;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (req1Ready) cnt++; end
    chk("cancelNoReady1", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    drain();
    chk("cancelDoneCnt", 32'(doneCnt), 32'd5);

    // Run up to 255, then one more op wraps the counter.
    for (int i = 5; i < 255; i++)
      doOp(1'($urandom_range(0, 1)), 13'($urandom), 13'($urandom));
    drain();
    chk("doneCnt255", 32'(doneCnt), 32'd255);
    doOp(1'b1, 13'h0001, 13'h0002);
    drain();
    chk("doneCntWrap", 32'(doneCnt), 32'd0);

    // SETTLE=3: latency, response held while consumer stalls, then next grant.
    req1One = 13'h0777; req1Other = 13'h0101; s3Req1Valid = 1'b1; s3RspReady = 1'b0;
    @(negedge clk);
    chk("s3Grant1", 32'(s3Req1Ready), 32'd1);
    @(posedge clk); #1;
    s3Req1Valid = 1'b0;
    req0One = 13'h0002; req0Other = 13'h0003; s3Req0Valid = 1'b1;
    n = 0; cnt = 0;
    while (!s3RspValid && n < 10) begin @(negedge clk); n++; if (s3Req0Ready) cnt++; end
    chk("s3Latency", 32'(n), 32'd4);
    chk("s3RspId", 32'(s3RspId), 32'd1);
    chk("s3RspData", 32'(s3RspData), 32'(addModel(13'h0777, 13'h0101)));
    holdData = addModel(13'h0777, 13'h0101);
    holdId = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (s3Req0Ready) cnt++;
      chk($sformatf("s3HoldData_%0d", i), 32'(s3RspData), 32'(holdData));
      chk($sformatf("s3HoldId_%0d", i), 32'(s3RspId), 32'(holdId));
    end
    chk("s3NoGrantWhileStalled", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    s3RspReady = 1'b1;
    @(negedge clk);
    chk("s3NoGrantOnAccept", 32'(s3Req0Ready), 32'd0);
    @(posedge clk); #1;
    s3RspReady = 1'b0;
    @(negedge clk);
    chk("s3GrantAfterAccept", 32'(s3Req0Ready), 32'd1);
    chk("s3RspCleared", 32'(s3RspValid), 32'd0);
    chk("s3DoneCnt", 32'(s3DoneCnt), 32'd1);
    @(posedge clk); #1;
    s3Req0Valid = 1'b0;

    // Reset pulsed while an op is settling discards it.
    doOp(1'b0, 13'h0010, 13'h0020);
    drain();
    chk("preRstDoneCnt", 32'(doneCnt), 32'd1);
    doOp(1'b1, 13'h0030, 13'h0040);
    #1;
    reset_n = 1'b0;
    req0Valid = 1'b1;
    #1;
    chk("midRstBusy", 32'(busy), 32'd0);
    chk("midRstRspValid", 32'(rspValid), 32'd0);
    chk("midRstAddOne", 32'(addOne), 32'd0);
    chk("midRstDoneCnt", 32'(doneCnt), 32'd0);
    chk("midRstReady0", 32'(req0Ready), 32'd0);
    q.delete();
    @(negedge clk);
    req0Valid = 1'b0;
    #1;
    reset_n = 1'b1;
    expDone = 0;
    saw = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (rspValid) saw++; end
    chk("noRspAfterRst", 32'(saw), 32'd0);
    chk("postRstDoneCnt", 32'(doneCnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
